// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU front-end types and constants.
// Supplies the datapath width, the instruction size, the default reset
// vector and the entry format carried through the fetch buffer.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    localparam fetch_entry_t FETCH_ENTRY_NULL = '{pc: 32'h0000_0000, word: 32'h0000_0000};

    // Sequential fetch address; wraps naturally at the top of the address space
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small FIFO of fetched {pc, word} entries.
// The head entry is held in its own register so the decode-facing outputs
// come straight from flops and keep their last value when the FIFO drains
// or is flushed. Flush is synchronous and dominates push; a pop in the same
// cycle as a flush is simply absorbed by the flush.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] occupancy,
    output fetch_entry_t     head
);

    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(1'b0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    fetch_entry_t     mem_r [DEPTH];
    fetch_entry_t     head_r;
    fetch_entry_t     head_next_s;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_ptr_adv_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic [CNT_W-1:0] remain_s;
    logic             do_pop_s;

    // Next count, read pointer and head entry after this cycle's pop/push/flush
    always_comb begin
        do_pop_s     = 1'b0;
        rd_ptr_adv_s = rd_ptr_r;
        remain_s     = count_r;
        count_next_s = count_r;
        head_next_s  = head_r;
        if (pop && (count_r != CNT_ZERO)) begin
            do_pop_s     = 1'b1;
            rd_ptr_adv_s = rd_ptr_r + PTR_ONE;
            remain_s     = count_r - CNT_ONE;
        end else begin
            do_pop_s     = 1'b0;
            rd_ptr_adv_s = rd_ptr_r;
            remain_s     = count_r;
        end
        if (flush) begin
            count_next_s = CNT_ZERO;
            head_next_s  = head_r;
        end else begin
            if (push) begin
                count_next_s = remain_s + CNT_ONE;
            end else begin
                count_next_s = remain_s;
            end
            if (remain_s != CNT_ZERO) begin
                head_next_s = mem_r[rd_ptr_adv_s];
            end else if (push) begin
                head_next_s = push_entry;
            end else begin
                head_next_s = head_r;
            end
        end
    end

    // Entry storage: write at the tail unless a flush discards the entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= FETCH_ENTRY_NULL;
            end
        end else if (push && !flush) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    // Pointers, occupancy and the registered head entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            head_r   <= FETCH_ENTRY_NULL;
        end else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            head_r   <= head_next_s;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r <= rd_ptr_adv_s;
            count_r  <= count_next_s;
            head_r   <= head_next_s;
        end
    end

    assign occupancy = count_r;
    assign head      = head_r;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: front-end fetch stage feeding instruction_decode.
// Owns the PC, requests words from a 1-cycle-latency synchronous memory,
// buffers the returned words with their PCs and hands them to decode over
// valid/ready. A redirect reloads the PC and flushes everything in flight.
// Optional build macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect target
// raises a sticky o_FetchFault and halts fetch until an aligned redirect.
// Without it, target bits [1:0] are cleared and o_FetchFault stays 0.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int BUFFER_DEPTH = 2
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    output logic        o_MemReadEnable,
    output logic [31:0] o_MemAddress,
    input  logic [31:0] i_MemData,
    input  logic        i_Redirect,
    input  logic [31:0] i_RedirectTarget,
    output logic        o_InstrValid,
    output logic [31:0] o_InstrWord,
    output logic [31:0] o_InstrPc,
    input  logic        i_InstrReady,
    output logic        o_FetchFault
);

    localparam int CNT_W = $clog2(BUFFER_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_LIMIT = BUFFER_DEPTH[CNT_W:0];
    localparam logic [CNT_W:0] DEM_ZERO    = {(CNT_W + 1){1'b0}};
    localparam logic [CNT_W:0] DEM_ONE     = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  req_pc_r;
    logic             inflight_r;
    logic             fault_r;
    logic             fault_next_s;
    logic [XLEN-1:0]  redirect_pc_s;
    logic             issue_s;
    logic             pop_s;
    logic             instr_valid_s;
    logic [CNT_W:0]   demand_s;
    logic [CNT_W-1:0] occupancy_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_s;

`ifdef FETCH_MISALIGN_CHECK_EN
    // Keep the raw target; a misaligned one sets the sticky fault, an aligned one clears it
    always_comb begin
        redirect_pc_s = i_RedirectTarget;
        fault_next_s  = fault_r;
        if (i_Redirect) begin
            fault_next_s = (i_RedirectTarget[1:0] != 2'b00);
        end else begin
            fault_next_s = fault_r;
        end
    end
`else
    // Force the target onto a word boundary; no fault is ever reported
    always_comb begin
        redirect_pc_s = i_RedirectTarget & ALIGN_MASK;
        fault_next_s  = 1'b0;
    end
`endif

    // Pop and issue decisions: room is judged after this cycle's pop, and redirect blocks issue
    always_comb begin
        instr_valid_s = (occupancy_s != CNT_ZERO);
        pop_s         = instr_valid_s & i_InstrReady;
        demand_s      = {1'b0, occupancy_s}
                      + (inflight_r ? DEM_ONE : DEM_ZERO)
                      - (pop_s ? DEM_ONE : DEM_ZERO);
        issue_s       = 1'b0;
        if (i_Reset) begin
            issue_s = 1'b0;
        end else if (i_Redirect) begin
            issue_s = 1'b0;
        end else if (fault_r) begin
            issue_s = 1'b0;
        end else if (demand_s < DEPTH_LIMIT) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Response entry pairs the returned word with the address that requested it
    always_comb begin
        push_entry_s.pc   = req_pc_r;
        push_entry_s.word = i_MemData;
    end

    // Program counter: redirect beats sequential advance
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            pc_r <= RESET_VECTOR;
        end else if (i_Redirect) begin
            pc_r <= redirect_pc_s;
        end else if (issue_s) begin
            pc_r <= next_pc(pc_r);
        end
    end

    // Outstanding read tracking; a response landing in a redirect cycle is killed by the flush
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            inflight_r <= 1'b0;
            req_pc_r   <= RESET_VECTOR;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                req_pc_r <= pc_r;
            end
        end
    end

    // Sticky misaligned-redirect fault
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_next_s;
        end
    end

    fetch_buffer #(
        .DEPTH(BUFFER_DEPTH)
    ) u_fetch_buffer (
        .clk       (i_Clock),
        .rst       (i_Reset),
        .push      (inflight_r),
        .push_entry(push_entry_s),
        .pop       (pop_s),
        .flush     (i_Redirect),
        .occupancy (occupancy_s),
        .head      (head_s)
    );

    assign o_MemReadEnable = issue_s;
    assign o_MemAddress    = pc_r;
    assign o_InstrValid    = instr_valid_s;
    assign o_InstrWord     = head_s.word;
    assign o_InstrPc       = head_s.pc;
    assign o_FetchFault    = fault_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed bench for instruction_fetch.
// Memory returns address ^ 32'hA5A5_A5A5 one cycle after each request.
// A stream model predicts the next issue address and the next delivered PC;
// directed checks pin latency, backpressure, redirect and reset timing.
module tb_instruction_fetch;

    localparam logic [31:0] PAT = 32'hA5A5_A5A5;
    localparam logic [31:0] RV  = 32'h0000_0000;

    logic        clk;
    logic        i_Reset;
    logic        o_MemReadEnable;
    logic [31:0] o_MemAddress;
    logic [31:0] i_MemData;
    logic        i_Redirect;
    logic [31:0] i_RedirectTarget;
    logic        o_InstrValid;
    logic [31:0] o_InstrWord;
    logic [31:0] o_InstrPc;
    logic        i_InstrReady;
    logic        o_FetchFault;

    int vectors = 0;
    int miscompares = 0;

    // Stream model state (owned by the compare process)
    logic [31:0] exp_pc;
    logic [31:0] exp_issue;
    logic        prev_valid;
    logic        prev_ready;
    logic        prev_redir;
    logic        prev_rst;
    logic [31:0] prev_pc;
    logic [31:0] prev_word;

    instruction_fetch dut (
        .i_Clock         (clk),
        .i_Reset         (i_Reset),
        .o_MemReadEnable (o_MemReadEnable),
        .o_MemAddress    (o_MemAddress),
        .i_MemData       (i_MemData),
        .i_Redirect      (i_Redirect),
        .i_RedirectTarget(i_RedirectTarget),
        .o_InstrValid    (o_InstrValid),
        .o_InstrWord     (o_InstrWord),
        .o_InstrPc       (o_InstrPc),
        .i_InstrReady    (i_InstrReady),
        .o_FetchFault    (o_FetchFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory with one cycle of read latency
    always @(posedge clk) begin
        if (o_MemReadEnable) i_MemData <= o_MemAddress ^ PAT;
        else i_MemData <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs change just after the rising edge, checks at the falling edge
    task automatic cyc(input logic rst, input logic rdy, input logic redir, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        i_Reset = rst;
        i_InstrReady = rdy;
        i_Redirect = redir;
        i_RedirectTarget = tgt;
        @(negedge clk);
    endtask

    // Per-cycle comparison against the stream model
    initial begin
        prev_rst = 1'b1;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_redir = 1'b0;
        prev_pc = 32'h0;
        prev_word = 32'h0;
        exp_pc = RV;
        exp_issue = RV;
        forever begin
            @(negedge clk);
            if (i_Reset) begin
                check("rst_valid", {31'd0, o_InstrValid}, 32'd0);
                check("rst_re", {31'd0, o_MemReadEnable}, 32'd0);
                check("rst_addr", o_MemAddress, RV);
                check("rst_word", o_InstrWord, 32'd0);
                check("rst_pc", o_InstrPc, 32'd0);
                check("rst_fault", {31'd0, o_FetchFault}, 32'd0);
                exp_pc = RV;
                exp_issue = RV;
            end else begin
                if (o_MemReadEnable) begin
                    check("issue_addr", o_MemAddress, exp_issue);
                    exp_issue = exp_issue + 32'd4;
                end
                if (i_Redirect) check("redir_no_issue", {31'd0, o_MemReadEnable}, 32'd0);
                if (o_InstrValid) check("word_of_pc", o_InstrWord, o_InstrPc ^ PAT);
                if (!prev_rst) begin
                    if (prev_valid && !prev_ready && !prev_redir) begin
                        check("stall_valid", {31'd0, o_InstrValid}, 32'd1);
                        check("stall_pc", o_InstrPc, prev_pc);
                        check("stall_word", o_InstrWord, prev_word);
                    end else if (!o_InstrValid) begin
                        check("empty_pc", o_InstrPc, prev_pc);
                        check("empty_word", o_InstrWord, prev_word);
                    end
                end
                if (o_InstrValid && i_InstrReady) begin
                    check("stream_pc", o_InstrPc, exp_pc);
                    exp_pc = exp_pc + 32'd4;
                end
                if (i_Redirect) begin
                    exp_pc = i_RedirectTarget & 32'hFFFF_FFFC;
                    exp_issue = i_RedirectTarget & 32'hFFFF_FFFC;
                end
            end
            prev_rst = i_Reset;
            prev_valid = o_InstrValid;
            prev_ready = i_InstrReady;
            prev_redir = i_Redirect;
            prev_pc = o_InstrPc;
            prev_word = o_InstrWord;
        end
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        i_Reset = 1'b1;
        i_InstrReady = 1'b1;
        i_Redirect = 1'b0;
        i_RedirectTarget = 32'h0;
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'h0);

        // Streaming from reset: issue every cycle, first instruction in cycle 2
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("a0_re", {31'd0, o_MemReadEnable}, 32'd1);
        check("a0_addr", o_MemAddress, 32'h0);
        check("a0_valid", {31'd0, o_InstrValid}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("a1_addr", o_MemAddress, 32'h4);
        check("a1_valid", {31'd0, o_InstrValid}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("a2_valid", {31'd0, o_InstrValid}, 32'd1);
        check("a2_pc", o_InstrPc, 32'h0);
        check("a2_word", o_InstrWord, 32'hA5A5_A5A5);
        for (int k = 3; k < 10; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            check("a_valid", {31'd0, o_InstrValid}, 32'd1);
            check("a_re", {31'd0, o_MemReadEnable}, 32'd1);
            check("a_addr", o_MemAddress, 32'(4 * k));
            check("a_pc", o_InstrPc, 32'(4 * (k - 2)));
        end

        // Mid-stream reset takes effect without waiting for a clock edge
        @(posedge clk);
        #1;
        i_Reset = 1'b1;
        #1;
        check("async_valid", {31'd0, o_InstrValid}, 32'd0);
        check("async_re", {31'd0, o_MemReadEnable}, 32'd0);
        check("async_addr", o_MemAddress, RV);
        check("async_pc", o_InstrPc, 32'd0);
        check("async_word", o_InstrWord, 32'd0);
        @(negedge clk);

        // Restart with backpressure on the first instruction for 5 cycles
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("b0_addr", o_MemAddress, RV);
        check("b0_re", {31'd0, o_MemReadEnable}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("b1_addr", o_MemAddress, 32'h4);
        for (int k = 2; k < 7; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            check("b_stall_re", {31'd0, o_MemReadEnable}, 32'd0);
            check("b_stall_pc", o_InstrPc, 32'h0);
        end
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("b7_pc", o_InstrPc, 32'h0);
        check("b7_addr", o_MemAddress, 32'h8);
        check("b7_re", {31'd0, o_MemReadEnable}, 32'd1);
        for (int k = 8; k < 12; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            check("b_valid", {31'd0, o_InstrValid}, 32'd1);
            check("b_pc", o_InstrPc, 32'(4 * (k - 7)));
        end

        // Redirect while a read is in flight; the popped head still completes
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        check("c12_pc", o_InstrPc, 32'd20);
        check("c12_re", {31'd0, o_MemReadEnable}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("c13_valid", {31'd0, o_InstrValid}, 32'd0);
        check("c13_addr", o_MemAddress, 32'h100);
        check("c13_re", {31'd0, o_MemReadEnable}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("c14_valid", {31'd0, o_InstrValid}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("c15_valid", {31'd0, o_InstrValid}, 32'd1);
        check("c15_pc", o_InstrPc, 32'h100);
        check("c15_word", o_InstrWord, 32'hA5A5_A4A5);

        // Fill the buffer, then back-to-back redirects to 0x40 and 0x80
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("d16_pc", o_InstrPc, 32'h104);
        check("d16_re", {31'd0, o_MemReadEnable}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        check("d17_valid", {31'd0, o_InstrValid}, 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0080);
        check("d18_valid", {31'd0, o_InstrValid}, 32'd0);
        check("d18_re", {31'd0, o_MemReadEnable}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("d19_addr", o_MemAddress, 32'h80);
        check("d19_re", {31'd0, o_MemReadEnable}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("d20_valid", {31'd0, o_InstrValid}, 32'd0);
        for (int k = 21; k < 24; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            check("d_valid", {31'd0, o_InstrValid}, 32'd1);
            check("d_pc", o_InstrPc, 32'(32'h80 + 4 * (k - 21)));
        end

        // Misaligned redirect target
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0102);
        check("e24_pc", o_InstrPc, 32'h8C);
        check("e24_fault", {31'd0, o_FetchFault}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int k = 25; k < 27; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            check("e_fault", {31'd0, o_FetchFault}, 32'd1);
            check("e_re", {31'd0, o_MemReadEnable}, 32'd0);
            check("e_valid", {31'd0, o_InstrValid}, 32'd0);
        end
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        check("e27_fault", {31'd0, o_FetchFault}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("e28_fault", {31'd0, o_FetchFault}, 32'd0);
        check("e28_re", {31'd0, o_MemReadEnable}, 32'd1);
        check("e28_addr", o_MemAddress, 32'h200);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("e30_valid", {31'd0, o_InstrValid}, 32'd1);
        check("e30_pc", o_InstrPc, 32'h200);
`else
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("e25_fault", {31'd0, o_FetchFault}, 32'd0);
        check("e25_re", {31'd0, o_MemReadEnable}, 32'd1);
        check("e25_addr", o_MemAddress, 32'h100);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("e27_valid", {31'd0, o_InstrValid}, 32'd1);
        check("e27_pc", o_InstrPc, 32'h100);
`endif
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
